// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// Packs the enabled TPL ADC channels into dense NUM_CHANNELS-sample words with a 1-deep output reg.
// Optional packed_sof output is compiled in when ADC_PACK_SOF_EN is defined.
module ad_ip_jesd204_tpl_adc_pack #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CHANNELS-1:0]              enable,
  input  logic [NUM_CHANNELS-1:0]              adc_valid,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] adc_data,
  output logic                                 packed_valid,
  input  logic                                 packed_ready,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] packed_data,
`ifdef ADC_PACK_SOF_EN
  output logic                                 packed_sof,
`endif
  output logic                                 adc_dovf
);

  localparam int unsigned Slots = 2 * NUM_CHANNELS;
  localparam int unsigned FillW = $clog2(Slots);
  localparam int unsigned DataW = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam logic [FillW-1:0] NumCh = FillW'(NUM_CHANNELS);

  logic [SAMPLE_WIDTH-1:0] hold_q   [Slots];
  logic [SAMPLE_WIDTH-1:0] hold_d   [Slots];
  logic [SAMPLE_WIDTH-1:0] hold_ext [Slots];

  logic [FillW-1:0]        fill_q, fill_d;
  logic [FillW-1:0]        n_en, total, wr_idx;
  logic [NUM_CHANNELS-1:0] enable_q;
  logic                    load_pending_q;

  logic                    valid_q, valid_d;
  logic [DataW-1:0]        data_q, data_d;
  logic                    dovf_q, dovf_d;

  logic                    beat, en_change, word_done, load;
  logic [DataW-1:0]        word;

  // Only adc_valid[0] qualifies a beat; the other lanes are ignored.
  logic                    unused_valid;
  assign unused_valid = ^adc_valid;

  assign beat      = adc_valid[0] && (enable != '0);
  // The first nonzero enable after reset only loads enable_q; it is not a change.
  assign en_change = !load_pending_q && (enable != enable_q);

  // Append enabled samples above the current fill level in ascending channel order.
  always_comb begin
    hold_ext = hold_q;
    n_en     = '0;
    wr_idx   = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (enable[k]) begin
        wr_idx           = fill_q + n_en;
        hold_ext[wr_idx] = adc_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        n_en             = n_en + FillW'(1);
      end
    end
    total = fill_q + n_en;
  end

  always_comb begin
    hold_d    = hold_q;
    fill_d    = fill_q;
    word      = '0;
    word_done = 1'b0;
    if (en_change) begin
      for (int i = 0; i < Slots; i++) begin
        hold_d[i] = '0;
      end
      fill_d = '0;
    end else if (beat) begin
      if (total >= NumCh) begin
        word_done = 1'b1;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          word[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = hold_ext[i];
          hold_d[i]                            = hold_ext[i + NUM_CHANNELS];
          hold_d[i + NUM_CHANNELS]             = '0;
        end
        fill_d = total - NumCh;
      end else begin
        hold_d = hold_ext;
        fill_d = total;
      end
    end
  end

  // A completed word may replace the held one only when that one drains this cycle.
  assign load = word_done && (!valid_q || packed_ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dovf_d  = word_done && valid_q && !packed_ready;
    if (load) begin
      valid_d = 1'b1;
      data_d  = word;
    end else if (valid_q && packed_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Slots; i++) begin
        hold_q[i] <= '0;
      end
      fill_q         <= '0;
      enable_q       <= '0;
      load_pending_q <= 1'b1;
      valid_q        <= 1'b0;
      data_q         <= '0;
      dovf_q         <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      fill_q   <= fill_d;
      enable_q <= enable;
      if (load_pending_q && (enable != '0)) begin
        load_pending_q <= 1'b0;
      end
      valid_q  <= valid_d;
      data_q   <= data_d;
      dovf_q   <= dovf_d;
    end
  end

  assign packed_valid = valid_q;
  assign packed_data  = data_q;
  assign adc_dovf     = dovf_q;

`ifdef ADC_PACK_SOF_EN
  logic sof_pend_q, sof_q;

  // Armed by reset or an enable change, consumed by the next word that reaches the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sof_pend_q <= 1'b1;
      sof_q      <= 1'b0;
    end else begin
      if (en_change) begin
        sof_pend_q <= 1'b1;
      end else if (load) begin
        sof_pend_q <= 1'b0;
      end
      if (load) begin
        sof_q <= sof_pend_q;
      end
    end
  end

  assign packed_sof = sof_q;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pack.sv
// Scoreboard bench for ad_ip_jesd204_tpl_adc_pack (NUM_CHANNELS=4, SAMPLE_WIDTH=16).
// A sample-queue model predicts words; the monitor pops and compares on each handshake.
module tb_ad_ip_jesd204_tpl_adc_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  enable;
  logic [3:0]  adc_valid;
  logic [63:0] adc_data;
  logic        packed_valid;
  logic        packed_ready;
  logic [63:0] packed_data;
  logic        adc_dovf;
`ifdef ADC_PACK_SOF_EN
  logic        packed_sof;
`endif

  ad_ip_jesd204_tpl_adc_pack #(
    .NUM_CHANNELS(4),
    .SAMPLE_WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .packed_valid (packed_valid),
    .packed_ready (packed_ready),
    .packed_data  (packed_data),
`ifdef ADC_PACK_SOF_EN
    .packed_sof   (packed_sof),
`endif
    .adc_dovf     (adc_dovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        sof;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] sq[$];
  logic [3:0]  m_en;
  bit          m_armed;
  logic        m_sof;
  bit          dovf_allow = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a flat queue of accepted samples, cut into 4-sample words.
  task automatic model_cycle(input logic [3:0] en, input logic vld, input logic [63:0] d);
    exp_t e;
    if (m_armed && (en != m_en)) begin
      sq.delete();
      m_sof = 1'b1;
    end else if (vld && (en != 4'h0)) begin
      for (int k = 0; k < 4; k++) begin
        if (en[k]) sq.push_back(d[k*16 +: 16]);
      end
      while (sq.size() >= 4) begin
        e.data = '0;
        for (int s = 0; s < 4; s++) e.data[s*16 +: 16] = sq.pop_front();
        e.sof = m_sof;
        m_sof = 1'b0;
        exp_q.push_back(e);
      end
    end
    if (en != 4'h0) m_armed = 1'b1;
    m_en = en;
  endtask

  task automatic drive_cycle(input logic [3:0] en, input logic vld, input logic [63:0] d);
    enable    = en;
    adc_valid = {3'($urandom), vld};
    adc_data  = d;
    model_cycle(en, vld, d);
    @(posedge clk);
    #1;
    adc_valid = '0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (!dovf_allow) check_eq("no_dovf", 64'(adc_dovf), 64'd0);
      if (packed_valid && packed_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", packed_data);
        end else begin
          e = exp_q.pop_front();
          check_eq("word", packed_data, e.data);
`ifdef ADC_PACK_SOF_EN
          check_eq("sof", 64'(packed_sof), 64'(e.sof));
`endif
        end
      end
    end
  end

  initial begin
    logic [3:0]  cur_en;
    logic [63:0] w1, w2, z;

    enable       = '0;
    adc_valid    = '0;
    adc_data     = '0;
    packed_ready = 1'b1;
    m_en         = '0;
    m_armed      = 1'b0;
    m_sof        = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(packed_valid), 64'd0);
    check_eq("rst_data", packed_data, 64'd0);
    check_eq("rst_dovf", 64'(adc_dovf), 64'd0);
    reset = 1'b0;
    repeat (2) drive_cycle(4'h0, 1'b0, '0);

    // All channels: one word per beat, 1-cycle latency, back-to-back drain+load.
    drive_cycle(4'hf, 1'b1, 64'h0003_0002_0001_0000);
    check_eq("lat_valid", 64'(packed_valid), 64'd1);
    check_eq("lat_data", packed_data, 64'h0003_0002_0001_0000);
    for (int i = 0; i < 6; i++) drive_cycle(4'hf, 1'b1, rnd64());
    drive_cycle(4'hf, 1'b0, '0);

    // Channels 0 and 2: two beats make one word.
    drive_cycle(4'h5, 1'b0, '0);
    drive_cycle(4'h5, 1'b1, 64'h0000_0c00_0000_0a00);
    check_eq("pair_wait", 64'(packed_valid), 64'd0);
    drive_cycle(4'h5, 1'b1, 64'h0000_0c01_0000_0a01);
    check_eq("pair_data", packed_data, 64'h0c01_0a01_0c00_0a00);

    // Three channels: samples wrap across words without gaps.
    drive_cycle(4'h7, 1'b0, '0);
    for (int i = 0; i < 8; i++) drive_cycle(4'h7, 1'b1, rnd64());
    drive_cycle(4'h7, 1'b0, '0);

    // Partial discarded on enable change, including the beat in the change cycle.
    drive_cycle(4'h3, 1'b0, '0);
    drive_cycle(4'h3, 1'b1, rnd64());
    drive_cycle(4'hf, 1'b1, rnd64());
    check_eq("chg_no_word", 64'(packed_valid), 64'd0);
    z = rnd64();
    drive_cycle(4'hf, 1'b1, z);
    check_eq("chg_data", packed_data, z);
    drive_cycle(4'hf, 1'b0, '0);

    // Random enables and beats with the sink always ready.
    cur_en = 4'hf;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) cur_en = 4'($urandom);
      drive_cycle(cur_en, 1'($urandom_range(0, 3) != 0), rnd64());
    end

    // Overflow: first word held, second dropped with a one-cycle pulse.
    drive_cycle(4'h0, 1'b0, '0);
    drive_cycle(4'hf, 1'b0, '0);
    drive_cycle(4'hf, 1'b0, '0);
    check_eq("pre_ovf_empty", 64'(exp_q.size()), 64'd0);
    packed_ready = 1'b0;
    dovf_allow   = 1'b1;
    w1 = rnd64();
    w2 = rnd64();
    drive_cycle(4'hf, 1'b1, w1);
    check_eq("ovf_valid", 64'(packed_valid), 64'd1);
    check_eq("ovf_dovf0", 64'(adc_dovf), 64'd0);
    drive_cycle(4'hf, 1'b1, w2);
    check_eq("ovf_dovf1", 64'(adc_dovf), 64'd1);
    check_eq("ovf_hold", packed_data, w1);
    void'(exp_q.pop_back());
    drive_cycle(4'hf, 1'b0, '0);
    check_eq("ovf_dovf_end", 64'(adc_dovf), 64'd0);
    check_eq("ovf_hold2", packed_data, w1);
    check_eq("ovf_valid2", 64'(packed_valid), 64'd1);
    dovf_allow   = 1'b0;
    packed_ready = 1'b1;
    drive_cycle(4'hf, 1'b0, '0);
    drive_cycle(4'hf, 1'b0, '0);

    // Reset while a word is pending clears outputs immediately.
    packed_ready = 1'b0;
    drive_cycle(4'hf, 1'b1, rnd64());
    check_eq("rst2_pre_valid", 64'(packed_valid), 64'd1);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check_eq("rst2_valid", 64'(packed_valid), 64'd0);
    check_eq("rst2_data", packed_data, 64'd0);
    check_eq("rst2_dovf", 64'(adc_dovf), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst2_dovf_hold", 64'(adc_dovf), 64'd0);
    sq.delete();
    m_en         = '0;
    m_armed      = 1'b0;
    m_sof        = 1'b1;
    reset        = 1'b0;
    packed_ready = 1'b1;
    z = rnd64();
    drive_cycle(4'hf, 1'b1, z);
    check_eq("post_rst_valid", 64'(packed_valid), 64'd1);
    check_eq("post_rst_data", packed_data, z);

    repeat (3) drive_cycle(4'hf, 1'b0, '0);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_pack.md
AD_IP_JESD204_TPL_ADC_PACK -- requirements
Module: ad_ip_jesd204_tpl_adc_pack

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: converter channels and output word slots, range 1..16.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16: bits per sample.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, the TPL link clock.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high, driven from the TPL adc_rst.
REQ-005 SHALL have port enable, input, NUM_CHANNELS bits: per-channel enable from the TPL regmap.
REQ-006 SHALL have port adc_valid, input, NUM_CHANNELS bits: per-channel valid from the TPL; only bit 0 is used.
REQ-007 SHALL have port adc_data, input, NUM_CHANNELS*SAMPLE_WIDTH bits: channel k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-008 SHALL have port packed_valid, output, 1 bit: packed word available.
REQ-009 SHALL have port packed_ready, input, 1 bit: sink accepts the word.
REQ-010 SHALL have port packed_data, output, NUM_CHANNELS*SAMPLE_WIDTH bits: packed samples, slot 0 in the LSBs.
REQ-011 SHALL have port adc_dovf, output, 1 bit: one-cycle overflow pulse, returned to the TPL adc_dovf.

Function
REQ-012 A beat SHALL be a cycle with adc_valid[0]=1 and enable != 0; all other cycles are ignored.
REQ-013 On each beat the samples of enabled channels SHALL be appended to a holding buffer in ascending channel order.
REQ-014 The holding buffer SHALL be 2*NUM_CHANNELS slots, with fill count F in 0..2*NUM_CHANNELS-1.
REQ-015 When F plus the number of enabled channels (N_EN) reaches or exceeds NUM_CHANNELS, the lowest NUM_CHANNELS slots SHALL form a completed word.
REQ-016 On word completion the remaining slots SHALL shift down and F SHALL become F+N_EN-NUM_CHANNELS.
REQ-017 Non-power-of-two N_EN SHALL wrap samples across word boundaries with no gaps and no padding.
REQ-018 A completed word SHALL appear on packed_data with packed_valid=1 in the cycle after the completing beat, giving 1-cycle latency.
REQ-019 The output register SHALL hold packed_data and packed_valid stable until packed_valid=1 and packed_ready=1.
REQ-020 A word completing while the output register is full and not draining in that cycle SHALL be dropped, and adc_dovf SHALL be 1 for the following cycle.
REQ-021 A word completing in the same cycle as a drain (packed_valid=1, packed_ready=1) SHALL be loaded without overflow.
REQ-022 A change of enable from its registered copy SHALL clear F to 0 and discard the partial samples, including any samples of a beat in that same cycle.
REQ-023 The pending output word SHALL be kept when enable changes.
REQ-024 When F=0 and N_EN=NUM_CHANNELS, each beat SHALL produce exactly one word equal to adc_data.

Reset
REQ-025 While reset=1 the outputs SHALL be: packed_valid=0, packed_data=0, adc_dovf=0.
REQ-026 While reset=1 the internal state SHALL be: F=0, registered enable=0, holding buffer=0.
REQ-027 Reset asserted mid-word SHALL discard partial and pending data immediately, with no overflow pulse.
REQ-028 After reset deassertion, the first beat SHALL NOT be treated as an enable change beyond the register load.

Configuration
REQ-029 The feature SHALL be controlled by macro ADC_PACK_SOF_EN.
REQ-030 When ADC_PACK_SOF_EN is defined, the block SHALL provide output packed_sof, 1 bit, reset 0, valid alongside packed_data.
REQ-031 packed_sof SHALL be 1 on the first word after reset or after an enable change, and 0 on all other words.
REQ-032 When ADC_PACK_SOF_EN is undefined, port packed_sof and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Scenario: NUM_CHANNELS=4, enable=4'b1111, packed_ready=1, beat of data 0x0003_0002_0001_0000 -> next cycle packed_valid=1, packed_data=0x0003_0002_0001_0000.
REQ-034 Scenario: enable=4'b0101, beats {ch0=A0, ch2=C0} then {A1, C1} -> one word {C1,A1,C0,A0} (slot 3..0) after the second beat.
REQ-035 Scenario: enable=4'b0111, 4 beats -> 3 words with no gaps, and F=0 after the 4th beat.
REQ-036 Scenario: packed_ready=0, enable=4'b1111, 2 beats -> first word held, second dropped, adc_dovf=1 for exactly one cycle.
REQ-037 Scenario: enable=4'b0011 with F=2 (after 1 beat), then enable changed to 4'b1111 -> partial discarded; with ADC_PACK_SOF_EN, the next word has packed_sof=1.
REQ-038 Scenario: reset asserted while packed_valid=1 -> packed_valid=0 and packed_data=0 the same cycle, with no adc_dovf pulse.
